// File: rtl/hub75_pkg.sv
// Shared HUB75 receive types and derived sizing helpers.
package hub75_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  localparam int unsigned HPIXEL_DEF   = 64;
  localparam int unsigned VPIXEL_DEF   = 64;
  localparam int unsigned BPP_DEF      = 8;
  localparam int unsigned SEGMENTS_DEF = 2;

  // Bit width able to index n items; never less than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Number of row addresses on a panel driven with the given segment count.
  function automatic int unsigned rows_of(input int unsigned vpixel, input int unsigned segments);
    return vpixel / segments;
  endfunction

  localparam int unsigned ROWS_DEF    = rows_of(VPIXEL_DEF, SEGMENTS_DEF);
  localparam int unsigned ROW_W_DEF   = width_of(ROWS_DEF);
  localparam int unsigned ADDR_W_DEF  = width_of(HPIXEL_DEF * VPIXEL_DEF);
  localparam int unsigned PLANE_W_DEF = width_of(BPP_DEF);

endpackage

// File: rtl/hub75_sync_edge.sv
// Two-flop synchronizer for one HUB75 control line with rise/fall pulses.
module hub75_sync_edge
  import hub75_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values of the synchronizer chain and the edge-history stage.
  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Two metastability stages plus one history stage; reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q;
  assign o_rise = sync_q & ~prev_q;
  assign o_fall = ~sync_q & prev_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: captures shifted lines, decodes bit planes, drains columns
// through a valid/ready write port and measures OE-low durations.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int unsigned hpixel_p    = 64,
  parameter int unsigned vpixel_p    = 64,
  parameter int unsigned bpp_p       = 8,
  parameter int unsigned segments_p  = 2,
  parameter int unsigned oe_cnt_wd_p = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_hub_clk,
  input  logic                                        i_hub_lat,
  input  logic                                        i_hub_oe_n,
  input  logic [width_of(vpixel_p/segments_p)-1:0]    i_hub_addr,
  input  logic [3*segments_p-1:0]                     i_hub_rgb,
  output logic                                        o_wr_valid,
  input  logic                                        i_wr_ready,
  output logic [width_of(hpixel_p*vpixel_p)-1:0]      o_wr_addr,
  output logic [width_of(bpp_p)-1:0]                  o_wr_plane,
  output logic [3*segments_p-1:0]                     o_wr_data,
  output logic                                        o_oe_valid,
  output logic [oe_cnt_wd_p-1:0]                      o_oe_cycles,
  output logic                                        o_col_err,
  output logic                                        o_overrun,
  input  logic                                        i_clr_err
);

  localparam int unsigned ROWS_P  = rows_of(vpixel_p, segments_p);
  localparam int unsigned ROW_W   = width_of(ROWS_P);
  localparam int unsigned ADDR_W  = width_of(hpixel_p * vpixel_p);
  localparam int unsigned PLANE_W = width_of(bpp_p);
  localparam int unsigned RGB_W   = 3 * segments_p;
  localparam int unsigned IDX_W   = width_of(hpixel_p);
  localparam int unsigned COL_W   = width_of(hpixel_p + 1);

  // Synchronized control lines and their edges.
  logic hclk_sync, hclk_rise, hclk_fall;
  logic lat_sync, lat_rise, lat_fall;
  logic oe_n_sync, oe_n_rise, oe_n_fall;

  hub75_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_hub_clk),
    .o_sync (hclk_sync),
    .o_rise (hclk_rise),
    .o_fall (hclk_fall)
  );

  hub75_sync_edge #(.RST_VAL(1'b0)) u_sync_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_hub_lat),
    .o_sync (lat_sync),
    .o_rise (lat_rise),
    .o_fall (lat_fall)
  );

  // OE_n idles high, so its chain resets high to avoid a false end-of-lit pulse.
  hub75_sync_edge #(.RST_VAL(1'b1)) u_sync_oe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_hub_oe_n),
    .o_sync (oe_n_sync),
    .o_rise (oe_n_rise),
    .o_fall (oe_n_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{hclk_sync, hclk_fall, lat_sync, lat_fall};

  // Data buses go through the same two-flop depth so they align with the edges.
  logic [ROW_W-1:0] addr_meta_q, addr_meta_d, addr_sync_q, addr_sync_d;
  logic [RGB_W-1:0] rgb_meta_q, rgb_meta_d, rgb_sync_q, rgb_sync_d;

  // Line capture, hold buffer, plane tracking and error flags.
  logic [RGB_W-1:0]   line_q [hpixel_p];
  logic [RGB_W-1:0]   line_d [hpixel_p];
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic [RGB_W-1:0]   hold_line_q [hpixel_p];
  logic [RGB_W-1:0]   hold_line_d [hpixel_p];
  logic [ROW_W-1:0]   hold_row_q, hold_row_d;
  logic [PLANE_W-1:0] hold_plane_q, hold_plane_d;
  logic [COL_W-1:0]   hold_cols_q, hold_cols_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic               row_seen_q, row_seen_d;
  logic               col_err_q, col_err_d;
  logic               overrun_q, overrun_d;
  logic               latch_accept;

  // Drainer.
  drain_state_e       state_q, state_d;
  logic [IDX_W-1:0]   dcol_q, dcol_d;

  // OE-low duration measurement.
  logic [oe_cnt_wd_p-1:0] oe_cnt_q, oe_cnt_d;
  logic [oe_cnt_wd_p-1:0] oe_cycles_q, oe_cycles_d;
  logic                   oe_valid_q, oe_valid_d;

  // Two-flop synchronizer next values for the address and colour buses.
  always_comb begin
    addr_meta_d = i_hub_addr;
    addr_sync_d = addr_meta_q;
    rgb_meta_d  = i_hub_rgb;
    rgb_sync_d  = rgb_meta_q;
  end

  // Shift capture, latch handling, plane sequencing and sticky error flags.
  always_comb begin
    line_d       = line_q;
    col_cnt_d    = col_cnt_q;
    hold_line_d  = hold_line_q;
    hold_row_d   = hold_row_q;
    hold_plane_d = hold_plane_q;
    hold_cols_d  = hold_cols_q;
    plane_d      = plane_q;
    last_row_d   = last_row_q;
    row_seen_d   = row_seen_q;
    col_err_d    = i_clr_err ? 1'b0 : col_err_q;
    overrun_d    = i_clr_err ? 1'b0 : overrun_q;
    latch_accept = 1'b0;

    // The shift is applied first so a same-cycle latch captures this column.
    if (hclk_rise && (col_cnt_q < COL_W'(hpixel_p))) begin
      line_d[col_cnt_q[IDX_W-1:0]] = rgb_sync_q;
      col_cnt_d                    = col_cnt_q + COL_W'(1);
    end

    if (lat_rise) begin
      if (row_seen_q && (addr_sync_q == last_row_q)) begin
        plane_d = (plane_q == PLANE_W'(bpp_p - 1)) ? '0 : plane_q + PLANE_W'(1);
      end else begin
        plane_d = '0;
      end
      last_row_d = addr_sync_q;
      row_seen_d = 1'b1;

      if (col_cnt_d != COL_W'(hpixel_p)) begin
        col_err_d = 1'b1;
      end

      if (state_q == ST_IDLE) begin
        latch_accept = 1'b1;
        hold_line_d  = line_d;
        hold_row_d   = addr_sync_q;
        hold_plane_d = plane_d;
        hold_cols_d  = col_cnt_d;
      end else begin
        // A busy drainer keeps its line; the new one is dropped.
        overrun_d = 1'b1;
      end

      col_cnt_d = '0;
    end
  end

  // Drainer next-state and write-valid output.
  always_comb begin
    state_d    = state_q;
    dcol_d     = dcol_q;
    o_wr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (latch_accept) begin
          state_d = ST_DRAIN;
          dcol_d  = '0;
        end
      end
      ST_DRAIN: begin
        o_wr_valid = 1'b1;
        if (i_wr_ready) begin
          if (dcol_q == IDX_W'(hpixel_p - 1)) begin
            state_d = ST_IDLE;
            dcol_d  = '0;
          end else begin
            dcol_d = dcol_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        dcol_d  = '0;
      end
    endcase
  end

  // Drainer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dcol_q  <= '0;
    end else begin
      state_q <= state_d;
      dcol_q  <= dcol_d;
    end
  end

  // OE counter: counts lit cycles, reports and restarts at the end of the window.
  always_comb begin
    oe_cnt_d    = oe_cnt_q;
    oe_cycles_d = oe_cycles_q;
    oe_valid_d  = 1'b0;
    if (oe_n_rise) begin
      oe_cycles_d = oe_cnt_q;
      oe_valid_d  = 1'b1;
      oe_cnt_d    = '0;
    end else if (oe_n_fall) begin
      oe_cnt_d = oe_cnt_wd_p'(1);
    end else if (!oe_n_sync && (oe_cnt_q != '1)) begin
      oe_cnt_d = oe_cnt_q + oe_cnt_wd_p'(1);
    end
  end

  // Datapath, plane, error and OE registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_meta_q  <= '0;
      addr_sync_q  <= '0;
      rgb_meta_q   <= '0;
      rgb_sync_q   <= '0;
      for (int i = 0; i < int'(hpixel_p); i++) begin
        line_q[i]      <= '0;
        hold_line_q[i] <= '0;
      end
      col_cnt_q    <= '0;
      hold_row_q   <= '0;
      hold_plane_q <= '0;
      hold_cols_q  <= '0;
      plane_q      <= '0;
      last_row_q   <= '0;
      row_seen_q   <= 1'b0;
      col_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
      oe_cnt_q     <= '0;
      oe_cycles_q  <= '0;
      oe_valid_q   <= 1'b0;
    end else begin
      addr_meta_q  <= addr_meta_d;
      addr_sync_q  <= addr_sync_d;
      rgb_meta_q   <= rgb_meta_d;
      rgb_sync_q   <= rgb_sync_d;
      line_q       <= line_d;
      hold_line_q  <= hold_line_d;
      col_cnt_q    <= col_cnt_d;
      hold_row_q   <= hold_row_d;
      hold_plane_q <= hold_plane_d;
      hold_cols_q  <= hold_cols_d;
      plane_q      <= plane_d;
      last_row_q   <= last_row_d;
      row_seen_q   <= row_seen_d;
      col_err_q    <= col_err_d;
      overrun_q    <= overrun_d;
      oe_cnt_q     <= oe_cnt_d;
      oe_cycles_q  <= oe_cycles_d;
      oe_valid_q   <= oe_valid_d;
    end
  end

  // Columns beyond the shifted count read as zero.
  assign o_wr_addr   = ADDR_W'(hold_row_q) * ADDR_W'(hpixel_p) + ADDR_W'(dcol_q);
  assign o_wr_plane  = hold_plane_q;
  assign o_wr_data   = (COL_W'(dcol_q) < hold_cols_q) ? hold_line_q[dcol_q] : '0;
  assign o_oe_valid  = oe_valid_q;
  assign o_oe_cycles = oe_cycles_q;
  assign o_col_err   = col_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx with randomized lines and a line-level model.
`timescale 1ns/1ps
module tb_hub75_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hub_clk = 1'b0;
  logic        i_hub_lat = 1'b0;
  logic        i_hub_oe_n = 1'b1;
  logic [4:0]  i_hub_addr = '0;
  logic [5:0]  i_hub_rgb = '0;
  logic        o_wr_valid;
  logic        i_wr_ready = 1'b1;
  logic [11:0] o_wr_addr;
  logic [2:0]  o_wr_plane;
  logic [5:0]  o_wr_data;
  logic        o_oe_valid;
  logic [15:0] o_oe_cycles;
  logic        o_col_err;
  logic        o_overrun;
  logic        i_clr_err = 1'b0;

  always #5 clk = ~clk;

  hub75_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hub_clk  (i_hub_clk),
    .i_hub_lat  (i_hub_lat),
    .i_hub_oe_n (i_hub_oe_n),
    .i_hub_addr (i_hub_addr),
    .i_hub_rgb  (i_hub_rgb),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (i_wr_ready),
    .o_wr_addr  (o_wr_addr),
    .o_wr_plane (o_wr_plane),
    .o_wr_data  (o_wr_data),
    .o_oe_valid (o_oe_valid),
    .o_oe_cycles(o_oe_cycles),
    .o_col_err  (o_col_err),
    .o_overrun  (o_overrun),
    .i_clr_err  (i_clr_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  plane;
    logic [5:0]  data;
    int          cyc;
  } wr_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   stall_changes = 0;
  bit   stall_hold = 1'b0;
  logic [11:0] st_addr;
  logic [2:0]  st_plane;
  logic [5:0]  st_data;

  // Plane model: same row as the previous latch advances mod 8, else restart.
  bit m_seen = 1'b0;
  int m_last = 0;
  int m_plane = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write collector and stall-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_hold = 1'b0;
    end else if (o_wr_valid) begin
      if (stall_hold && ((o_wr_addr !== st_addr) || (o_wr_plane !== st_plane) || (o_wr_data !== st_data)))
        stall_changes++;
      if (i_wr_ready) begin
        wq.push_back('{addr: o_wr_addr, plane: o_wr_plane, data: o_wr_data, cyc: cyc});
        stall_hold = 1'b0;
      end else begin
        stall_hold = 1'b1;
        st_addr    = o_wr_addr;
        st_plane   = o_wr_plane;
        st_data    = o_wr_data;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_plane(input int row);
    if (m_seen && row == m_last) m_plane = (m_plane + 1) % 8;
    else m_plane = 0;
    m_seen = 1'b1;
    m_last = row;
    return m_plane;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hub_shift(input logic [5:0] rgb);
    i_hub_rgb = rgb;
    wait_clks(2);
    i_hub_clk = 1'b1;
    wait_clks(3);
    i_hub_clk = 1'b0;
    wait_clks(2);
  endtask

  task automatic hub_latch(input logic [4:0] row);
    i_hub_addr = row;
    wait_clks(2);
    i_hub_lat = 1'b1;
    wait_clks(3);
    i_hub_lat = 1'b0;
    wait_clks(2);
  endtask

  task automatic hub_shift_latch(input logic [5:0] rgb, input logic [4:0] row);
    i_hub_rgb  = rgb;
    i_hub_addr = row;
    wait_clks(2);
    i_hub_clk = 1'b1;
    i_hub_lat = 1'b1;
    wait_clks(3);
    i_hub_clk = 1'b0;
    i_hub_lat = 1'b0;
    wait_clks(2);
  endtask

  task automatic pulse_clr();
    i_clr_err = 1'b1;
    wait_clks(1);
    i_clr_err = 1'b0;
    wait_clks(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    m_seen  = 1'b0;
    m_plane = 0;
    wq.delete();
  endtask

  task automatic drain_wait(input bit rand_ready);
    int guard = 0;
    while ((wq.size() < 64 || o_wr_valid) && guard < 3000) begin
      if (rand_ready) i_wr_ready = 1'($urandom_range(0, 1));
      else i_wr_ready = 1'b1;
      wait_clks(1);
      guard++;
    end
    i_wr_ready = 1'b1;
    chk("drain_timeout", 32'(guard < 3000), 32'd1);
  endtask

  task automatic check_line(input logic [5:0] s [64], input int nshift, input int row,
                            input int plane, input string tag, input bit consec);
    logic [5:0] ed;
    chk({tag, "_count"}, 32'(wq.size()), 32'd64);
    for (int c = 0; c < 64 && c < wq.size(); c++) begin
      ed = (c < nshift) ? s[c] : 6'd0;
      chk($sformatf("%s_col%0d", tag, c), {11'd0, wq[c].addr, wq[c].plane, wq[c].data},
          {11'd0, 12'(row * 64 + c), 3'(plane), ed});
    end
    if (consec && wq.size() == 64) chk({tag, "_span"}, 32'(wq[63].cyc - wq[0].cyc), 32'd63);
  endtask

  task automatic run_line(input int nshift, input int row, input bit rand_ready,
                          input bit simul, input bit pat, input string tag);
    logic [5:0] samp [64];
    int plane;
    for (int c = 0; c < 64; c++) samp[c] = pat ? 6'(c) : 6'($urandom);
    pulse_clr();
    wq.delete();
    for (int c = 0; c < nshift; c++) begin
      if (simul && c == nshift - 1) hub_shift_latch(samp[c], 5'(row));
      else hub_shift(samp[c]);
    end
    if (!simul) hub_latch(5'(row));
    plane = model_plane(row);
    drain_wait(rand_ready);
    check_line(samp, nshift, row, plane, tag, !rand_ready);
    chk({tag, "_col_err"}, 32'(o_col_err), 32'(nshift != 64));
    chk({tag, "_overrun"}, 32'(o_overrun), 32'd0);
  endtask

  initial begin
    logic [5:0] sa [64];
    int pa;
    int got;
    logic [15:0] oe_val;

    // Reset state
    do_reset();
    chk("rst_wr_valid", 32'(o_wr_valid), 32'd0);
    chk("rst_oe_valid", 32'(o_oe_valid), 32'd0);
    chk("rst_oe_cycles", 32'(o_oe_cycles), 32'd0);
    chk("rst_col_err", 32'(o_col_err), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);

    // Counter pattern on row 5
    run_line(64, 5, 1'b0, 1'b0, 1'b1, "pattern");

    // Plane sequencing on row 3 (wraps after eight), then row 4
    for (int k = 0; k < 9; k++) run_line(64, 3, 1'b0, 1'b0, 1'b0, $sformatf("row3_%0d", k));
    run_line(64, 4, 1'b0, 1'b0, 1'b0, "row4");

    // Back-pressure during drain
    stall_changes = 0;
    run_line(64, 12, 1'b1, 1'b0, 1'b0, "ready_toggle");
    chk("stall_stable", 32'(stall_changes), 32'd0);

    // Short line: 63 shifts
    run_line(63, 20, 1'b0, 1'b0, 1'b0, "short");

    // Last shift coincides with the latch
    run_line(64, 21, 1'b0, 1'b1, 1'b0, "simul");

    // Overrun: second latch while the first line is stalled
    do_reset();
    i_wr_ready = 1'b0;
    for (int c = 0; c < 64; c++) sa[c] = 6'($urandom);
    for (int c = 0; c < 64; c++) hub_shift(sa[c]);
    hub_latch(5'd9);
    pa = model_plane(9);
    chk("ovr_flag_before", 32'(o_overrun), 32'd0);
    wait_clks(3);
    hub_latch(5'd9);
    void'(model_plane(9));
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    chk("ovr_col_err", 32'(o_col_err), 32'd1);
    chk("ovr_stalled", 32'(wq.size()), 32'd0);
    drain_wait(1'b0);
    check_line(sa, 64, 9, pa, "ovr_line", 1'b1);
    chk("ovr_flag_held", 32'(o_overrun), 32'd1);
    pulse_clr();
    chk("ovr_cleared", 32'(o_overrun), 32'd0);
    chk("col_err_cleared", 32'(o_col_err), 32'd0);

    // OE-low duration
    i_hub_oe_n = 1'b0;
    wait_clks(200);
    i_hub_oe_n = 1'b1;
    got = 0;
    oe_val = '0;
    for (int k = 0; k < 20; k++) begin
      wait_clks(1);
      if (o_oe_valid) begin
        got++;
        oe_val = o_oe_cycles;
      end
    end
    chk("oe_pulse_count", 32'(got), 32'd1);
    chk("oe_cycles_range", 32'((oe_val >= 16'd198) && (oe_val <= 16'd202)), 32'd1);

    // Reset in the middle of a stalled drain
    i_wr_ready = 1'b0;
    wq.delete();
    for (int c = 0; c < 64; c++) hub_shift(6'($urandom_range(1, 63)));
    hub_latch(5'd7);
    wait_clks(2);
    chk("pre_rst_valid", 32'(o_wr_valid), 32'd1);
    chk("pre_rst_addr", 32'(o_wr_addr), 32'd448);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_wr_valid), 32'd0);
    chk("mid_rst_addr", 32'(o_wr_addr), 32'd0);
    chk("mid_rst_data", 32'(o_wr_data), 32'd0);
    chk("mid_rst_plane", 32'(o_wr_plane), 32'd0);
    chk("mid_rst_oe_cycles", 32'(o_oe_cycles), 32'd0);
    chk("mid_rst_oe_valid", 32'(o_oe_valid), 32'd0);
    chk("mid_rst_overrun", 32'(o_overrun), 32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    m_seen = 1'b0;
    wq.delete();
    i_wr_ready = 1'b1;
    wait_clks(100);
    chk("post_rst_writes", 32'(wq.size()), 32'd0);
    chk("post_rst_valid", 32'(o_wr_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
